decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 213 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32 subset instruction decoder with a two-entry
// output buffer (OUT register plus one skid register). Each accepted
// word is decoded combinationally before it is captured. Upstream
// ready depends only on skid occupancy, so it never combinationally
// follows out_ready.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int M_EXT = 1,
  parameter int OPW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ins,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [OPW-1:0]  out_op_type,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  // Operation codes presented on out_op_type
  localparam logic [OPW-1:0] I_NULL  = OPW'(0);
  localparam logic [OPW-1:0] I_ERR   = OPW'(1);
  localparam logic [OPW-1:0] I_ADD   = OPW'(2);
  localparam logic [OPW-1:0] I_SUB   = OPW'(3);
  localparam logic [OPW-1:0] I_MUL   = OPW'(4);
  localparam logic [OPW-1:0] I_MULH  = OPW'(5);
  localparam logic [OPW-1:0] I_XOR   = OPW'(6);
  localparam logic [OPW-1:0] I_OR    = OPW'(7);
  localparam logic [OPW-1:0] I_AND   = OPW'(8);
  localparam logic [OPW-1:0] I_ADDI  = OPW'(9);
  localparam logic [OPW-1:0] I_BEQ   = OPW'(10);
  localparam logic [OPW-1:0] I_BNE   = OPW'(11);
  localparam logic [OPW-1:0] I_BLT   = OPW'(12);
  localparam logic [OPW-1:0] I_BGE   = OPW'(13);
  localparam logic [OPW-1:0] I_LW    = OPW'(14);
  localparam logic [OPW-1:0] I_SW    = OPW'(15);
  localparam logic [OPW-1:0] I_JAL   = OPW'(16);
  localparam logic [OPW-1:0] I_LUI   = OPW'(17);
  localparam logic [OPW-1:0] I_AUIPC = OPW'(18);

  typedef enum logic [2:0] {
    FMT_X, FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [OPW-1:0]  op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  localparam entry_t EMPTY = '{pc: '0, op: I_NULL, rs1: '0, rs2: '0,
                               rd: '0, imm: '0, illegal: 1'b0};

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [OPW-1:0]  dec_op;
  fmt_e            fmt;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  entry_t          dec;

  entry_t out_q, skid_q;
  logic   out_valid_q, skid_valid_q;
  logic   accept, keep, out_load;

  assign opcode = in_ins[6:0];
  assign funct3 = in_ins[14:12];
  assign funct7 = in_ins[31:25];

  // Sign-extended immediates for each instruction format
  assign imm_i = XLEN'($signed(in_ins[31:20]));
  assign imm_s = XLEN'($signed({in_ins[31:25], in_ins[11:7]}));
  assign imm_b = XLEN'($signed({in_ins[31], in_ins[7], in_ins[30:25], in_ins[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({in_ins[31], in_ins[19:12], in_ins[20], in_ins[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({in_ins[31:12], 12'b0}));

  // Classify the word into an operation and its encoding format
  always_comb begin
    dec_op = I_ERR;
    fmt    = FMT_X;
    case (opcode)
      7'b0110011: begin
        case ({funct7, funct3})
          10'b0000000_000: begin dec_op = I_ADD; fmt = FMT_R; end
          10'b0100000_000: begin dec_op = I_SUB; fmt = FMT_R; end
          10'b0000000_100: begin dec_op = I_XOR; fmt = FMT_R; end
          10'b0000000_110: begin dec_op = I_OR;  fmt = FMT_R; end
          10'b0000000_111: begin dec_op = I_AND; fmt = FMT_R; end
          10'b0000001_000: begin
            if (M_EXT != 0) begin dec_op = I_MUL; fmt = FMT_R; end
          end
          10'b0000001_001: begin
            if (M_EXT != 0) begin dec_op = I_MULH; fmt = FMT_R; end
          end
          default: ;
        endcase
      end
      7'b0010011: if (funct3 == 3'b000) begin dec_op = I_ADDI; fmt = FMT_I; end
      7'b0000011: if (funct3 == 3'b010) begin dec_op = I_LW;   fmt = FMT_I; end
      7'b0100011: if (funct3 == 3'b010) begin dec_op = I_SW;   fmt = FMT_S; end
      7'b1100011: begin
        case (funct3)
          3'b000:  begin dec_op = I_BEQ; fmt = FMT_B; end
          3'b001:  begin dec_op = I_BNE; fmt = FMT_B; end
          3'b100:  begin dec_op = I_BLT; fmt = FMT_B; end
          3'b101:  begin dec_op = I_BGE; fmt = FMT_B; end
          default: ;
        endcase
      end
      7'b1101111: begin dec_op = I_JAL;   fmt = FMT_J; end
      7'b0110111: begin dec_op = I_LUI;   fmt = FMT_U; end
      7'b0010111: begin dec_op = I_AUIPC; fmt = FMT_U; end
      default: ;
    endcase
  end

  // Select register indices and immediate according to the format
  always_comb begin
    dec         = EMPTY;
    dec.pc      = in_pc;
    dec.op      = dec_op;
    dec.illegal = 1'b0;
    case (fmt)
      FMT_R: begin
        dec.rs1 = in_ins[19:15];
        dec.rs2 = in_ins[24:20];
        dec.rd  = in_ins[11:7];
      end
      FMT_I: begin
        dec.rs1 = in_ins[19:15];
        dec.rd  = in_ins[11:7];
        dec.imm = imm_i;
      end
      FMT_S: begin
        dec.rs1 = in_ins[19:15];
        dec.rs2 = in_ins[24:20];
        dec.imm = imm_s;
      end
      FMT_B: begin
        dec.rs1 = in_ins[19:15];
        dec.rs2 = in_ins[24:20];
        dec.imm = imm_b;
      end
      FMT_J: begin
        dec.rd  = in_ins[11:7];
        dec.imm = imm_j;
      end
      FMT_U: begin
        dec.rd  = in_ins[11:7];
        dec.imm = imm_u;
      end
      default: begin
        dec.op      = I_ERR;
        dec.illegal = 1'b1;
      end
    endcase
  end

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  // An all-zero word completes its handshake but is never stored
  assign keep     = accept & (in_ins != '0);
  assign out_load = ~out_valid_q | out_ready;

  // OUT/SKID buffer: SKID always drains into OUT before new input does
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= EMPTY;
      skid_q       <= EMPTY;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_load) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= keep;
        if (keep) skid_q <= dec;
      end else begin
        out_valid_q <= keep;
        if (keep) out_q <= dec;
      end
    end else if (keep) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_op_type = out_q.op;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_imm     = out_q.imm;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage. Two instances share the stimulus:
// "a" is XLEN=32 with M extension, "b" is XLEN=64 without it.
// Expected decodes are queued as words are accepted and checked as
// they leave the output register.
module tb_decode_stage;

  localparam logic [4:0] I_NULL = 5'd0,  I_ERR  = 5'd1,  I_ADD  = 5'd2,
                         I_SUB  = 5'd3,  I_MUL  = 5'd4,  I_MULH = 5'd5,
                         I_XOR  = 5'd6,  I_OR   = 5'd7,  I_AND  = 5'd8,
                         I_ADDI = 5'd9,  I_BEQ  = 5'd10, I_BNE  = 5'd11,
                         I_BLT  = 5'd12, I_BGE  = 5'd13, I_LW   = 5'd14,
                         I_SW   = 5'd15, I_JAL  = 5'd16, I_LUI  = 5'd17,
                         I_AUIPC = 5'd18;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic        ill;
    logic        mext;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_ins;
  logic [63:0] in_pc;

  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0] out_pc_a, out_imm_a;
  logic [4:0]  out_op_a, out_rs1_a, out_rs2_a, out_rd_a;

  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [63:0] out_pc_b, out_imm_b;
  logic [4:0]  out_op_b, out_rs1_b, out_rs2_b, out_rd_b;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .M_EXT(1), .OPW(5)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .in_ins(in_ins), .in_pc(in_pc[31:0]),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pc(out_pc_a), .out_op_type(out_op_a),
    .out_rs1(out_rs1_a), .out_rs2(out_rs2_a), .out_rd(out_rd_a),
    .out_imm(out_imm_a), .out_illegal(out_illegal_a)
  );

  decode_stage #(.XLEN(64), .M_EXT(0), .OPW(5)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_ins(in_ins), .in_pc(in_pc),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_pc(out_pc_b), .out_op_type(out_op_b),
    .out_rs1(out_rs1_b), .out_rs2(out_rs2_b), .out_rd(out_rd_b),
    .out_imm(out_imm_b), .out_illegal(out_illegal_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] pc, input logic [4:0] op,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [63:0] imm,
                              input logic ill, input logic mext);
    exp_t e;
    e.pc = pc; e.op = op; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.imm = imm; e.ill = ill; e.mext = mext;
    return e;
  endfunction

  // Present a word until it is accepted; queue its expectation if it should emerge
  task automatic send(input logic [31:0] ins, input logic [63:0] pc,
                      input exp_t e, input bit expect_out);
    bit ok = 1'b0;
    in_valid = 1'b1; in_ins = ins; in_pc = pc;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready_a) begin
        ok = 1'b1;
        if (expect_out) sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    chk("send_accepted", ok, 1);
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Output monitor: stall stability and in-order scoreboard compare
  exp_t        m_e;
  bit          m_held = 1'b0;
  logic [31:0] m_pc, m_imm;
  logic [4:0]  m_op;
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      m_held = 1'b0;
    end else begin
      if (m_held && out_valid_a) begin
        chk("stall_pc", out_pc_a, m_pc);
        chk("stall_op", out_op_a, m_op);
        chk("stall_imm", out_imm_a, m_imm);
      end
      if (out_valid_a && out_ready) begin
        chk("b_valid", out_valid_b, 1);
        chk("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          m_e = sb.pop_front();
          chk("a_pc", out_pc_a, m_e.pc[31:0]);
          chk("a_op", out_op_a, m_e.op);
          chk("a_rs1", out_rs1_a, m_e.rs1);
          chk("a_rs2", out_rs2_a, m_e.rs2);
          chk("a_rd", out_rd_a, m_e.rd);
          chk("a_imm", out_imm_a, m_e.imm[31:0]);
          chk("a_ill", out_illegal_a, m_e.ill);
          chk("b_pc", out_pc_b, m_e.pc);
          if (m_e.mext) begin
            chk("b_op", out_op_b, I_ERR);
            chk("b_idx", {out_rs1_b, out_rs2_b, out_rd_b}, 0);
            chk("b_imm", out_imm_b, 0);
            chk("b_ill", out_illegal_b, 1);
          end else begin
            chk("b_op", out_op_b, m_e.op);
            chk("b_idx", {out_rs1_b, out_rs2_b, out_rd_b}, {m_e.rs1, m_e.rs2, m_e.rd});
            chk("b_imm", out_imm_b, m_e.imm);
            chk("b_ill", out_illegal_b, m_e.ill);
          end
        end
      end
      m_held = out_valid_a && !out_ready;
      m_pc = out_pc_a; m_op = out_op_a; m_imm = out_imm_a;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  exp_t nx;
  initial begin
    nx = mk(0, I_NULL, 0, 0, 0, 0, 0, 0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ins = '0; in_pc = '0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_pc", out_pc_a, 0);
    chk("rst_op", out_op_a, I_NULL);
    chk("rst_idx", {out_rs1_a, out_rs2_a, out_rd_a}, 0);
    chk("rst_imm", out_imm_a, 0);
    chk("rst_ill", out_illegal_a, 0);
    chk("rst_b_op", out_op_b, I_NULL);
    chk("rst_b_valid", out_valid_b, 0);
    step(); step();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready_b, 1);
    chk("post_rst_out_valid", out_valid_b, 0);
    step();

    // Single addi: one-cycle latency
    out_ready = 1'b1;
    send(32'h00500093, 64'h100, mk(64'h100, I_ADDI, 0, 0, 1, 64'd5, 0, 0), 1);
    @(negedge clk);
    chk("latency_valid", out_valid_a, 1);
    step();

    // Back-to-back stream with full-rate output, including a bubble
    send(32'hFE000EE3, 64'h200, mk(64'h200, I_BEQ, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0), 1);
    send(32'h123452B7, 64'h204, mk(64'h204, I_LUI, 0, 0, 5, 64'h1234_5000, 0, 0), 1);
    send(32'h02208033, 64'h208, mk(64'h208, I_MUL, 1, 2, 0, 0, 0, 1), 1);
    send(32'h002081B3, 64'h20C, mk(64'h20C, I_ADD, 1, 2, 3, 0, 0, 0), 1);
    send(32'h402081B3, 64'h210, mk(64'h210, I_SUB, 1, 2, 3, 0, 0, 0), 1);
    send(32'h00000000, 64'h214, nx, 0);
    send(32'h0020C1B3, 64'h218, mk(64'h218, I_XOR, 1, 2, 3, 0, 0, 0), 1);
    send(32'h0020E1B3, 64'h21C, mk(64'h21C, I_OR, 1, 2, 3, 0, 0, 0), 1);
    send(32'h0020F1B3, 64'h220, mk(64'h220, I_AND, 1, 2, 3, 0, 0, 0), 1);
    send(32'h022091B3, 64'h224, mk(64'h224, I_MULH, 1, 2, 3, 0, 0, 1), 1);
    send(32'hFFF08093, 64'h228, mk(64'h228, I_ADDI, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0), 1);
    send(32'h00C12303, 64'h22C, mk(64'h22C, I_LW, 2, 0, 6, 64'd12, 0, 0), 1);
    send(32'hFE512C23, 64'h230, mk(64'h230, I_SW, 2, 5, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0), 1);
    send(32'h00209463, 64'h234, mk(64'h234, I_BNE, 1, 2, 0, 64'd8, 0, 0), 1);
    send(32'h0020C463, 64'h238, mk(64'h238, I_BLT, 1, 2, 0, 64'd8, 0, 0), 1);
    send(32'h0020D463, 64'h23C, mk(64'h23C, I_BGE, 1, 2, 0, 64'd8, 0, 0), 1);
    send(32'h001000EF, 64'h240, mk(64'h240, I_JAL, 0, 0, 1, 64'h800, 0, 0), 1);
    send(32'h8000006F, 64'h244, mk(64'h244, I_JAL, 0, 0, 0, 64'hFFFF_FFFF_FFF0_0000, 0, 0), 1);
    send(32'h80000397, 64'h248, mk(64'h248, I_AUIPC, 0, 0, 7, 64'hFFFF_FFFF_8000_0000, 0, 0), 1);
    send(32'hFFFFFFFF, 64'h24C, mk(64'h24C, I_ERR, 0, 0, 0, 0, 1, 0), 1);
    send(32'h00001013, 64'h250, mk(64'h250, I_ERR, 0, 0, 0, 0, 1, 0), 1);
    send(32'h4020C1B3, 64'h254, mk(64'h254, I_ERR, 0, 0, 0, 0, 1, 0), 1);
    step(); step();

    // Stalled output: two words buffered, third held off, then drained in order
    out_ready = 1'b0;
    send(32'h00100093, 64'h300, mk(64'h300, I_ADDI, 0, 0, 1, 64'd1, 0, 0), 1);
    send(32'h00200113, 64'h304, mk(64'h304, I_ADDI, 0, 0, 2, 64'd2, 0, 0), 1);
    in_valid = 1'b1; in_ins = 32'h00300193; in_pc = 64'h308;
    @(negedge clk);
    chk("full_in_ready", in_ready_a, 0);
    chk("full_out_valid", out_valid_a, 1);
    step();
    @(negedge clk);
    chk("full_in_ready_hold", in_ready_b, 0);
    step();
    out_ready = 1'b1;
    send(32'h00300193, 64'h308, mk(64'h308, I_ADDI, 0, 0, 3, 64'd3, 0, 0), 1);
    step(); step();

    // Flush with buffer full and an input offered
    out_ready = 1'b0;
    send(32'h00100093, 64'h400, nx, 0);
    send(32'h00200113, 64'h404, nx, 0);
    in_valid = 1'b1; in_ins = 32'h00300193; in_pc = 64'h408;
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_full_out_valid", out_valid_a, 0);
    chk("flush_full_in_ready", in_ready_a, 1);
    step();

    // Flush on the same edge an input is accepted: that input is discarded
    send(32'h00100093, 64'h410, nx, 0);
    in_valid = 1'b1; in_ins = 32'h00500213; in_pc = 64'h414;
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_acc_out_valid", out_valid_b, 0);
    chk("flush_acc_in_ready", in_ready_b, 1);
    step();
    out_ready = 1'b1;
    step(); step();
    send(32'h00600293, 64'h418, mk(64'h418, I_ADDI, 0, 0, 5, 64'd6, 0, 0), 1);
    step(); step();

    // Asynchronous reset while full
    out_ready = 1'b0;
    send(32'h00100093, 64'h500, nx, 0);
    send(32'h00200113, 64'h504, nx, 0);
    in_valid = 1'b1; in_ins = 32'h00300193; in_pc = 64'h508;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid_a, 0);
    chk("async_rst_in_ready", in_ready_a, 1);
    chk("async_rst_pc", out_pc_a, 0);
    chk("async_rst_op", out_op_a, I_NULL);
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("after_rst_out_valid", out_valid_a, 0);
    step();
    out_ready = 1'b1;
    send(32'h123452B7, 64'h600, mk(64'h600, I_LUI, 0, 0, 5, 64'h1234_5000, 0, 0), 1);

    // Drain and confirm nothing is left outstanding
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    step();
    chk("sb_drained", sb.size(), 0);
    @(negedge clk);
    chk("idle_out_valid", out_valid_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
